// File: rtl/tt_um_mux_arbiter.sv
// Round-robin owner of a shared 4:1 multiplexed output line.
// Four requesters compete for one output bit. A winner holds the line for
// HOLD+1 cycles, or less if it drops its request. Every grant is followed by
// one dead IDLE cycle before the next arbitration.
module tt_um_mux_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Field views of the input pins
  logic [3:0] data_in;
  logic [3:0] hold_in;
  logic [3:0] req_in;

  assign data_in = ui_in[3:0];
  assign hold_in = ui_in[7:4];
  assign req_in  = uio_in[3:0];

  // uio_in[7:4] carries nothing. It is consumed here so that it is not left floating.
  logic unused_uio_hi;
  assign unused_uio_hi = &{1'b0, uio_in[7:4]};

  // Registered state
  state_t     state_q, state_d;
  logic [1:0] sel_q,   sel_d;
  logic [1:0] last_q,  last_d;
  logic [3:0] cnt_q,   cnt_d;

  // Round-robin pick
  logic [1:0] winner;
  logic       winner_found;
  logic [1:0] cand;

  // Scan LAST+1 .. LAST+4 (mod 4). The first live request wins.
  // LAST itself is checked last, so the previous owner only wins again
  // when nobody else is asking.
  always_comb begin
    winner       = last_q;
    winner_found = 1'b0;
    cand         = '0;
    for (int k = 1; k < 5; k++) begin
      cand = last_q + 2'(k);
      if (!winner_found && req_in[cand]) begin
        winner       = cand;
        winner_found = 1'b1;
      end
    end
  end

  // Next-state logic. In GRANT, ena is checked first, then early release,
  // then the end of the hold window.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (ena && winner_found) begin
          sel_d   = winner;
          last_d  = winner;
          cnt_d   = hold_in;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!ena) begin
          state_d = ST_IDLE;
        end else if (!req_in[sel_q]) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register. After reset LAST=3, so channel 0 is scanned first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= 2'd0;
      last_q  <= 2'd3;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are decoded from registered state. The data bit is a live mux path.
  logic       busy;
  logic [3:0] gnt;
  logic       data_out;

  assign busy = (state_q == ST_GRANT);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_gnt
      assign gnt[gi] = busy & (sel_q == 2'(gi));
    end
  endgenerate

  assign data_out = busy & data_in[sel_q];

  assign uo_out  = {gnt, busy, sel_q, data_out};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_mux_arbiter.sv
// Bench for tt_um_mux_arbiter. A behavioural model predicts uo_out on every
// cycle. Directed scenarios pin the model with hand-computed bytes, and a
// randomized phase then exercises the design.
module tb_tt_um_mux_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int vectors = 0;
  int miscompares = 0;

  tt_um_mux_arbiter dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  // Behavioural model. The owner is tracked together with the number of
  // grant cycles it has used and the number it may use (HOLD+1).
  bit m_busy = 1'b0;
  int m_sel  = 0;
  int m_last = 3;
  int m_used = 0;
  int m_win  = 0;
  int m_limit = 1;
  bit m_found = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_sel  = 0;
      m_last = 3;
      m_used = 0;
    end else if (m_busy) begin
      if (!ena || !uio_in[m_sel] || m_used >= m_limit) m_busy = 1'b0;
      else m_used = m_used + 1;
    end else if (ena) begin
      m_found = 1'b0;
      m_win   = 0;
      for (int k = 1; k <= 4; k++) begin
        if (!m_found && uio_in[(m_last + k) % 4]) begin
          m_found = 1'b1;
          m_win   = (m_last + k) % 4;
        end
      end
      if (m_found) begin
        m_busy  = 1'b1;
        m_sel   = m_win;
        m_last  = m_win;
        m_limit = int'(ui_in[7:4]) + 1;
        m_used  = 1;
      end
    end
  end

  function automatic logic [7:0] model_out();
    int v;
    v = m_sel * 2;
    if (m_busy) v = v + (1 << (4 + m_sel)) + 8 + int'(ui_in[m_sel]);
    return 8'(v);
  endfunction

  // Compare the DUT against the model on every falling edge.
  always @(negedge clk) begin
    logic [7:0] want;
    want = model_out();
    vectors++;
    if (uo_out !== want) begin
      miscompares++;
      $display("FAIL model_uo_out t=%0t got=%02h want=%02h", $time, uo_out, want);
    end
    vectors++;
    if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
      miscompares++;
      $display("FAIL uio_tie t=%0t got out=%02h oe=%02h want 00/00", $time, uio_out, uio_oe);
    end
  end

  task automatic check_lit(input string name, input logic [7:0] want);
    vectors++;
    if (uo_out !== want) begin
      miscompares++;
      $display("FAIL %s t=%0t got=%02h want=%02h", name, $time, uo_out, want);
    end else begin
      $display("ok   %s t=%0t uo_out=%02h", name, $time, uo_out);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Assert reset between falling edges and release it away from a rising edge.
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Bound the whole run.
  initial begin
    #2000000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] single_exp [5];
    logic [7:0] rr_exp [9];
    logic [3:0] req;
    single_exp = '{8'h19, 8'h19, 8'h19, 8'h00, 8'h19};
    rr_exp     = '{8'h18, 8'h00, 8'h2A, 8'h02, 8'h4C, 8'h04, 8'h8E, 8'h06, 8'h18};

    // Reset, then a single requester with HOLD=2 and D0=1
    ena = 1'b1;
    repeat (3) @(negedge clk);
    check_lit("reset_out", 8'h00);
    #2 rst_n = 1'b1;
    ui_in  = {4'd2, 4'b0001};
    uio_in = 8'h01;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      check_lit($sformatf("single_c%0d", i), single_exp[i]);
    end

    // Round-robin with every channel requesting and HOLD=0
    do_reset();
    ui_in  = 8'h00;
    uio_in = 8'h0F;
    for (int i = 0; i < 9; i++) begin
      next_cycle();
      check_lit($sformatf("rr_c%0d", i), rr_exp[i]);
    end

    // Priority rotation: after granting ch1, REQ=1011 goes to ch3, then ch0
    do_reset();
    ui_in  = 8'h00;
    uio_in = 8'h02;
    @(posedge clk);
    #1 uio_in = 8'h0B;
    @(negedge clk);
    check_lit("rot_ch1", 8'h2A);
    next_cycle();
    check_lit("rot_dead", 8'h02);
    next_cycle();
    check_lit("rot_ch3", 8'h8E);
    next_cycle();
    check_lit("rot_dead2", 8'h06);
    next_cycle();
    check_lit("rot_ch0", 8'h18);

    // Early release: HOLD=15, REQ2 dropped after three grant cycles
    do_reset();
    ui_in  = 8'hF0;
    uio_in = 8'h04;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      check_lit($sformatf("early_g%0d", i), 8'h4C);
    end
    #2 uio_in = 8'h00;
    next_cycle();
    check_lit("early_rel", 8'h04);
    #2 uio_in = 8'h04;
    next_cycle();
    check_lit("early_regrant", 8'h4C);

    // ena dropped mid-grant
    do_reset();
    ui_in  = 8'hF0;
    uio_in = 8'h01;
    next_cycle();
    check_lit("ena_grant", 8'h18);
    #2 ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      check_lit($sformatf("ena_off%0d", i), 8'h00);
    end
    #2 ena = 1'b1;
    next_cycle();
    check_lit("ena_back", 8'h18);

    // Reset pulsed mid-grant
    do_reset();
    ui_in  = 8'hF0;
    uio_in = 8'h04;
    next_cycle();
    check_lit("rst_grant", 8'h4C);
    #2 rst_n = 1'b0;
    #1 check_lit("rst_async", 8'h00);
    ui_in  = 8'h00;
    uio_in = 8'h0F;
    @(negedge clk);
    #2 rst_n = 1'b1;
    next_cycle();
    check_lit("rst_ch0", 8'h18);

    // Data path: channel 3 owns the line while its data bit toggles
    do_reset();
    ui_in  = {4'd7, 4'b1000};
    uio_in = 8'h08;
    next_cycle();
    check_lit("data_ch3", 8'h8F);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1 ui_in = {4'd7, ~ui_in[3], 3'($urandom)};
    end

    // Randomized traffic with sticky requests, rare ena drops and resets
    req = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      ui_in  = {4'($urandom_range(0, 4)), 4'($urandom)};
      uio_in = {4'($urandom), req};
      ena    = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
